// File: rtl/iic_cfg_pkg.sv
// Shared definitions for the I2C register-configuration sequencer:
// table op-codes, FSM state encoding and table-entry field layout.
package iic_cfg_pkg;

   localparam logic [1:0] OP_WR  = 2'b00;
   localparam logic [1:0] OP_WRV = 2'b01;
   localparam logic [1:0] OP_DLY = 2'b10;
   localparam logic [1:0] OP_END = 2'b11;

   localparam int unsigned OP_W     = 2;
   localparam int unsigned REG_AW   = 16;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_PWRUP    = 4'd1,
      S_FETCH    = 4'd2,
      S_DECODE   = 4'd3,
      S_ISSUE_WR = 4'd4,
      S_WAIT_WR  = 4'd5,
      S_ISSUE_RD = 4'd6,
      S_WAIT_RD  = 4'd7,
      S_RETRY    = 4'd8,
      S_DLY      = 4'd9,
      S_NEXT     = 4'd10,
      S_DONE     = 4'd11,
      S_ERR      = 4'd12
   } state_t;

   // Entry layout is {op, reg_addr, data}; data sits in the low DATA_W bits.
   function automatic int unsigned addr_lsb(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned op_lsb(input int unsigned data_w);
      return data_w + REG_AW;
   endfunction

   function automatic longint unsigned max3_u(input longint unsigned a,
                                              input longint unsigned b,
                                              input longint unsigned c);
      longint unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/iic_cfg_seq.sv
// Walks an external register table and drives the iic_ctrl write/read
// handshake for each entry, with verify, delays, retries and timeouts.
module iic_cfg_seq
   import iic_cfg_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = 7'h1A,
   parameter int unsigned TBL_DEPTH   = 64,
   parameter int unsigned ADDR_BYTES  = 1,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned MAX_RETRY   = 3,
   parameter int unsigned PWRUP_CYC   = 1_000_000,
   parameter int unsigned DLY_UNIT    = 50_000,
   parameter int unsigned TIMEOUT_CYC = 500_000,
   localparam int unsigned TBL_AW     = $clog2(TBL_DEPTH),
   localparam int unsigned ENT_W      = OP_W + REG_AW + DATA_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_auto_start,
   output logic [TBL_AW-1:0] o_tbl_addr,
   input  logic [ENT_W-1:0]  i_tbl_data,
   output logic              o_iic_wr_en,
   output logic              o_iic_rd_en,
   output logic [6:0]        o_iic_dev_addr,
   output logic [15:0]       o_iic_addr,
   output logic              o_iic_addr_num,
   output logic [DATA_W-1:0] o_iic_wdata,
   input  logic              i_iic_done,
   input  logic              i_iic_ack_err,
   input  logic [DATA_W-1:0] i_iic_rdata,
   output logic              o_busy,
   output logic              o_cfg_done,
   output logic              o_cfg_err,
   output logic [TBL_AW-1:0] o_err_idx
);

   // One shared cycle counter covers power-up, timeouts and the longest delay entry.
   localparam longint unsigned DLY_MAX = ((64'd1 << DATA_W) - 64'd1) * longint'(DLY_UNIT);
   localparam longint unsigned CNT_MAX = max3_u(longint'(PWRUP_CYC), longint'(TIMEOUT_CYC), DLY_MAX);
   localparam int unsigned     CNT_W   = $clog2(CNT_MAX + 64'd1);
   localparam int unsigned     RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [CNT_W:0]      PWRUP_LIM = (CNT_W+1)'(PWRUP_CYC);
   localparam logic [CNT_W:0]      TMO_LIM   = (CNT_W+1)'(TIMEOUT_CYC);
   localparam logic [TBL_AW-1:0]   IDX_LAST  = TBL_AW'(TBL_DEPTH - 1);
   localparam logic [RETRY_W-1:0]  RETRY_LIM = RETRY_W'(MAX_RETRY);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_tgt;
   logic [TBL_AW-1:0]   r_idx;
   logic [RETRY_W-1:0]  r_retry;
   logic [1:0]          r_op;
   logic [15:0]         r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_wr_en;
   logic                r_rd_en;
   logic                r_busy;
   logic                r_cfg_done;
   logic                r_cfg_err;
   logic [TBL_AW-1:0]   r_err_idx;
   logic                r_armed;

   logic [1:0]          w_ent_op;
   logic [15:0]         w_ent_addr;
   logic [DATA_W-1:0]   w_ent_data;
   logic [CNT_W:0]      w_cnt_inc;
   logic                w_go;

   assign w_ent_op   = i_tbl_data[op_lsb(DATA_W) +: OP_W];
   assign w_ent_addr = i_tbl_data[addr_lsb(DATA_W) +: REG_AW];
   assign w_ent_data = i_tbl_data[DATA_W-1:0];
   assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
   // r_armed is only high in the first cycle after reset release.
   assign w_go       = (r_state == S_IDLE) && (i_start || (r_armed && i_auto_start));

   // Next-state logic of the sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_go) w_state_nxt = S_PWRUP; else w_state_nxt = S_IDLE;
         S_PWRUP:    if (w_cnt_inc >= PWRUP_LIM) w_state_nxt = S_FETCH; else w_state_nxt = S_PWRUP;
         S_FETCH:    w_state_nxt = S_DECODE;
         S_DECODE: begin
            case (w_ent_op)
               OP_WR, OP_WRV: w_state_nxt = S_ISSUE_WR;
               OP_DLY:        if (w_ent_data == {DATA_W{1'b0}}) w_state_nxt = S_NEXT;
                              else w_state_nxt = S_DLY;
               OP_END:        w_state_nxt = S_DONE;
               default:       w_state_nxt = S_ERR;
            endcase
         end
         S_ISSUE_WR: w_state_nxt = S_WAIT_WR;
         S_WAIT_WR: begin
            if (i_iic_done) begin
               if (i_iic_ack_err)      w_state_nxt = S_RETRY;
               else if (r_op == OP_WRV) w_state_nxt = S_ISSUE_RD;
               else                    w_state_nxt = S_NEXT;
            end else if (w_cnt_inc >= TMO_LIM) begin
               w_state_nxt = S_RETRY;
            end else begin
               w_state_nxt = S_WAIT_WR;
            end
         end
         S_ISSUE_RD: w_state_nxt = S_WAIT_RD;
         S_WAIT_RD: begin
            if (i_iic_done) begin
               if (i_iic_ack_err || (i_iic_rdata != r_wdata)) w_state_nxt = S_RETRY;
               else                                          w_state_nxt = S_NEXT;
            end else if (w_cnt_inc >= TMO_LIM) begin
               w_state_nxt = S_RETRY;
            end else begin
               w_state_nxt = S_WAIT_RD;
            end
         end
         S_RETRY:    if (r_retry < RETRY_LIM) w_state_nxt = S_ISSUE_WR; else w_state_nxt = S_ERR;
         S_DLY:      if (w_cnt_inc >= {1'b0, r_tgt}) w_state_nxt = S_NEXT; else w_state_nxt = S_DLY;
         S_NEXT:     if (r_idx == IDX_LAST) w_state_nxt = S_DONE; else w_state_nxt = S_FETCH;
         S_DONE:     w_state_nxt = S_IDLE;
         S_ERR:      w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // State, counters, latched entry and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= {CNT_W{1'b0}};
         r_tgt      <= {CNT_W{1'b0}};
         r_idx      <= {TBL_AW{1'b0}};
         r_retry    <= {RETRY_W{1'b0}};
         r_op       <= 2'b00;
         r_addr     <= 16'h0000;
         r_wdata    <= {DATA_W{1'b0}};
         r_wr_en    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_busy     <= 1'b0;
         r_cfg_done <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_err_idx  <= {TBL_AW{1'b0}};
         r_armed    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_armed <= 1'b0;
         // Counter restarts on every state change so each state times itself.
         if ((w_state_nxt != r_state) || (r_state == S_IDLE))
            r_cnt <= {CNT_W{1'b0}};
         else
            r_cnt <= w_cnt_inc[CNT_W-1:0];

         if (w_go) begin
            r_idx      <= {TBL_AW{1'b0}};
            r_retry    <= {RETRY_W{1'b0}};
            r_cfg_done <= 1'b0;
            r_cfg_err  <= 1'b0;
         end
         if (r_state == S_NEXT) begin
            r_retry <= {RETRY_W{1'b0}};
            if (r_idx != IDX_LAST) r_idx <= r_idx + {{(TBL_AW-1){1'b0}}, 1'b1};
         end
         if ((r_state == S_RETRY) && (r_retry < RETRY_LIM))
            r_retry <= r_retry + {{(RETRY_W-1){1'b0}}, 1'b1};

         if (r_state == S_DECODE) begin
            r_op    <= w_ent_op;
            r_addr  <= (ADDR_BYTES == 1) ? {8'h00, w_ent_addr[7:0]} : w_ent_addr;
            r_wdata <= w_ent_data;
            r_tgt   <= CNT_W'(w_ent_data) * CNT_W'(DLY_UNIT);
         end

         r_wr_en <= (w_state_nxt == S_ISSUE_WR);
         r_rd_en <= (w_state_nxt == S_ISSUE_RD);
         r_busy  <= !(w_state_nxt inside {S_IDLE, S_DONE, S_ERR});
         if (w_state_nxt == S_DONE) r_cfg_done <= 1'b1;
         if (w_state_nxt == S_ERR) begin
            r_cfg_err <= 1'b1;
            r_err_idx <= r_idx;
         end
      end
   end

   assign o_tbl_addr     = r_idx;
   assign o_iic_wr_en    = r_wr_en;
   assign o_iic_rd_en    = r_rd_en;
   assign o_iic_dev_addr = DEV_ADDR;
   assign o_iic_addr     = r_addr;
   assign o_iic_addr_num = 1'(ADDR_BYTES - 1);
   assign o_iic_wdata    = r_wdata;
   assign o_busy         = r_busy;
   assign o_cfg_done     = r_cfg_done;
   assign o_cfg_err      = r_cfg_err;
   assign o_err_idx      = r_err_idx;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed bench for iic_cfg_seq: behavioural table ROM and iic_ctrl model,
// table-driven run vectors plus delay, reset and auto-start sequences.
module tb_iic_cfg_seq;
   import iic_cfg_pkg::*;

   localparam int DW = 8, DEPTH = 16, AW = 4, EW = 26, LAT = 20;

   logic          clk = 1'b0;
   logic          rst_n, start, auto_start;
   logic [AW-1:0] tbl_addr, err_idx;
   logic [EW-1:0] tbl_data;
   logic          iic_wr_en, iic_rd_en, iic_addr_num, iic_done, iic_ack_err;
   logic [6:0]    iic_dev_addr;
   logic [15:0]   iic_addr;
   logic [DW-1:0] iic_wdata, iic_rdata;
   logic          busy, cfg_done, cfg_err;

   always #5 clk = ~clk;

   iic_cfg_seq #(.TBL_DEPTH(DEPTH), .PWRUP_CYC(10), .DLY_UNIT(100), .TIMEOUT_CYC(50)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_auto_start(auto_start),
      .o_tbl_addr(tbl_addr), .i_tbl_data(tbl_data),
      .o_iic_wr_en(iic_wr_en), .o_iic_rd_en(iic_rd_en), .o_iic_dev_addr(iic_dev_addr),
      .o_iic_addr(iic_addr), .o_iic_addr_num(iic_addr_num), .o_iic_wdata(iic_wdata),
      .i_iic_done(iic_done), .i_iic_ack_err(iic_ack_err), .i_iic_rdata(iic_rdata),
      .o_busy(busy), .o_cfg_done(cfg_done), .o_cfg_err(cfg_err), .o_err_idx(err_idx));

   logic [EW-1:0] tbl [DEPTH];
   always @(posedge clk) tbl_data <= tbl[tbl_addr];

   // iic_ctrl model: done LAT cycles after each request; logs every write.
   int            cyc = 0, pend = 0, wr_total = 0, rd_total = 0;
   bit            pend_nack = 1'b0;
   logic [DW-1:0] last_wdata = 8'h00;
   logic [15:0]   wr_addr_log [256];
   logic [DW-1:0] wr_data_log [256];
   int            wr_cyc_log  [256];
   bit            m_rd_zero = 1'b0, m_no_done = 1'b0;
   int            m_nack_wr = -1;

   always @(posedge clk) begin
      cyc         <= cyc + 1;
      iic_done    <= 1'b0;
      iic_ack_err <= 1'b0;
      if (iic_wr_en) begin
         wr_addr_log[wr_total % 256] <= iic_addr;
         wr_data_log[wr_total % 256] <= iic_wdata;
         wr_cyc_log[wr_total % 256]  <= cyc;
         wr_total   <= wr_total + 1;
         last_wdata <= iic_wdata;
         pend       <= LAT;
         pend_nack  <= (wr_total == m_nack_wr);
      end else if (iic_rd_en) begin
         rd_total  <= rd_total + 1;
         pend      <= LAT;
         pend_nack <= 1'b0;
      end else if (pend > 0) begin
         pend <= pend - 1;
         if (pend == 1 && !m_no_done) begin
            iic_done    <= 1'b1;
            iic_ack_err <= pend_nack;
            iic_rdata   <= m_rd_zero ? 8'h00 : last_wdata;
         end
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] ent(input logic [1:0] op, input logic [15:0] a, input logic [7:0] d);
      return {op, a, d};
   endfunction

   typedef struct {
      string         name;
      logic [EW-1:0] e0, e1, e2, e3;
      bit            fill_wr, rd_zero, no_done, chk_log;
      int            nack_wr, exp_wr, exp_rd;
      bit            exp_done, exp_err;
      int            exp_idx;
   } vec_t;

   function automatic vec_t mk(input string n, input logic [EW-1:0] a, b, c, d,
                               input bit fill, rdz, nod, lg, input int nack, ew, er,
                               input bit ed, ee, input int ei);
      vec_t v;
      v.name = n; v.e0 = a; v.e1 = b; v.e2 = c; v.e3 = d;
      v.fill_wr = fill; v.rd_zero = rdz; v.no_done = nod; v.chk_log = lg;
      v.nack_wr = nack; v.exp_wr = ew; v.exp_rd = er;
      v.exp_done = ed; v.exp_err = ee; v.exp_idx = ei;
      return v;
   endfunction

   task automatic load(input vec_t v);
      for (int i = 0; i < DEPTH; i++)
         tbl[i] = v.fill_wr ? ent(OP_WR, 16'h0080 + 16'(i), 8'(i)) : ent(OP_END, 16'h0000, 8'h00);
      tbl[0] = v.e0; tbl[1] = v.e1; tbl[2] = v.e2; tbl[3] = v.e3;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_end(input string nm, input int budget);
      bit ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (!busy && (cfg_done || cfg_err)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({nm, "_ends"}, 32'(ok), 32'd1);
   endtask

   vec_t vecs [8];

   initial begin
      int w0, r0, g0, g1;
      vec_t v;
      rst_n = 1'b0; start = 1'b0; auto_start = 1'b0;
      v = mk("none", ent(OP_END, 16'h0, 8'h0), ent(OP_END, 16'h0, 8'h0), ent(OP_END, 16'h0, 8'h0),
             ent(OP_END, 16'h0, 8'h0), 0, 0, 0, 0, -1, 0, 0, 0, 0, 0);
      load(v);

      vecs[0] = mk("three_wr", ent(OP_WR, 16'h10, 8'h11), ent(OP_WR, 16'h20, 8'h22),
                   ent(OP_WR, 16'h30, 8'h33), ent(OP_END, 16'h0, 8'h0), 0, 0, 0, 1, -1, 3, 0, 1, 0, 0);
      vecs[1] = mk("wrv_ok", ent(OP_WRV, 16'h02, 8'h5A), ent(OP_END, 16'h0, 8'h0),
                   ent(OP_END, 16'h0, 8'h0), ent(OP_END, 16'h0, 8'h0), 0, 0, 0, 1, -1, 1, 1, 1, 0, 0);
      vecs[2] = mk("wrv_bad", ent(OP_WRV, 16'h02, 8'h5A), ent(OP_END, 16'h0, 8'h0),
                   ent(OP_END, 16'h0, 8'h0), ent(OP_END, 16'h0, 8'h0), 0, 1, 0, 0, -1, 4, 4, 0, 1, 0);
      vecs[3] = mk("nack1", ent(OP_WR, 16'h10, 8'h01), ent(OP_WR, 16'h11, 8'h02),
                   ent(OP_WR, 16'h12, 8'h03), ent(OP_END, 16'h0, 8'h0), 0, 0, 0, 0, 1, 4, 0, 1, 0, 0);
      vecs[4] = mk("full_tbl", ent(OP_WR, 16'h80, 8'h00), ent(OP_WR, 16'h81, 8'h01),
                   ent(OP_WR, 16'h82, 8'h02), ent(OP_WR, 16'h83, 8'h03), 1, 0, 0, 1, -1, 16, 0, 1, 0, 0);
      vecs[5] = mk("dly0", ent(OP_WR, 16'h44, 8'hA1), ent(OP_DLY, 16'h0, 8'h00),
                   ent(OP_WR, 16'h45, 8'hA2), ent(OP_END, 16'h0, 8'h0), 0, 0, 0, 0, -1, 2, 0, 1, 0, 0);
      vecs[6] = mk("timeout", ent(OP_WR, 16'h60, 8'h01), ent(OP_END, 16'h0, 8'h0),
                   ent(OP_END, 16'h0, 8'h0), ent(OP_END, 16'h0, 8'h0), 0, 0, 1, 0, -1, 4, 0, 0, 1, 0);
      vecs[7] = mk("err_idx2", ent(OP_WR, 16'h70, 8'h01), ent(OP_WR, 16'h71, 8'h02),
                   ent(OP_WRV, 16'h72, 8'h5A), ent(OP_END, 16'h0, 8'h0), 0, 1, 0, 0, -1, 6, 4, 0, 1, 2);

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_en", 32'(iic_wr_en), 32'd0);
      chk("rst_rd_en", 32'(iic_rd_en), 32'd0);
      chk("rst_done", 32'(cfg_done), 32'd0);
      chk("rst_err", 32'(cfg_err), 32'd0);
      chk("rst_tbl_addr", 32'(tbl_addr), 32'd0);
      chk("rst_dev_addr", 32'(iic_dev_addr), 32'h1A);
      chk("rst_addr_num", 32'(iic_addr_num), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_auto_busy", 32'(busy), 32'd0);

      for (int i = 0; i < 8; i++) begin
         load(vecs[i]);
         m_rd_zero = vecs[i].rd_zero;
         m_no_done = vecs[i].no_done;
         w0 = wr_total; r0 = rd_total;
         m_nack_wr = (vecs[i].nack_wr < 0) ? -1 : w0 + vecs[i].nack_wr;
         pulse_start();
         wait_end(vecs[i].name, 3000);
         chk({vecs[i].name, "_wr"}, 32'(wr_total - w0), 32'(vecs[i].exp_wr));
         chk({vecs[i].name, "_rd"}, 32'(rd_total - r0), 32'(vecs[i].exp_rd));
         chk({vecs[i].name, "_done"}, 32'(cfg_done), 32'(vecs[i].exp_done));
         chk({vecs[i].name, "_err"}, 32'(cfg_err), 32'(vecs[i].exp_err));
         if (vecs[i].exp_err) chk({vecs[i].name, "_idx"}, 32'(err_idx), 32'(vecs[i].exp_idx));
         if (vecs[i].chk_log) begin
            for (int j = 0; j < vecs[i].exp_wr; j++) begin
               chk({vecs[i].name, "_log_addr"}, 32'(wr_addr_log[(w0 + j) % 256]), 32'(tbl[j][23:8]));
               chk({vecs[i].name, "_log_data"}, 32'(wr_data_log[(w0 + j) % 256]), 32'(tbl[j][7:0]));
            end
         end
         m_no_done = 1'b0;
         repeat (30) @(negedge clk);
      end

      // A 3-tick delay entry adds 300 DLY cycles plus its own DECODE, NEXT and FETCH.
      v = mk("delay", ent(OP_WR, 16'h50, 8'h01), ent(OP_WR, 16'h51, 8'h02),
             ent(OP_DLY, 16'h0, 8'h03), ent(OP_WR, 16'h52, 8'h03), 0, 0, 0, 0, -1, 3, 0, 1, 0, 0);
      load(v);
      m_rd_zero = 1'b0; m_nack_wr = -1;
      w0 = wr_total;
      pulse_start();
      wait_end("delay", 3000);
      chk("delay_wr", 32'(wr_total - w0), 32'd3);
      g0 = wr_cyc_log[(w0 + 1) % 256] - wr_cyc_log[w0 % 256];
      g1 = wr_cyc_log[(w0 + 2) % 256] - wr_cyc_log[(w0 + 1) % 256];
      chk("delay_gap", 32'(g1 - g0), 32'd303);
      repeat (10) @(negedge clk);

      // Asynchronous reset in the middle of a write wait.
      load(vecs[0]);
      pulse_start();
      repeat (30) @(negedge clk);
      chk("mid_busy_before", 32'(busy), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy), 32'd0);
      chk("mid_wr_en", 32'(iic_wr_en), 32'd0);
      chk("mid_tbl_addr", 32'(tbl_addr), 32'd0);
      chk("mid_addr", 32'(iic_addr), 32'd0);
      chk("mid_wdata", 32'(iic_wdata), 32'd0);
      chk("mid_err_idx", 32'(err_idx), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      w0 = wr_total;
      repeat (40) @(negedge clk);
      chk("post_rst_no_wr", 32'(wr_total - w0), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
      pulse_start();
      repeat (30) @(negedge clk);
      pulse_start();
      wait_end("rerun", 3000);
      chk("rerun_wr", 32'(wr_total - w0), 32'd3);
      chk("rerun_first_addr", 32'(wr_addr_log[w0 % 256]), 32'h10);
      chk("rerun_done", 32'(cfg_done), 32'd1);
      repeat (30) @(negedge clk);

      // Auto-start at reset release.
      auto_start = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      w0 = wr_total;
      repeat (2) @(negedge clk);
      chk("auto_busy", 32'(busy), 32'd1);
      wait_end("auto", 3000);
      chk("auto_wr", 32'(wr_total - w0), 32'd3);
      chk("auto_done", 32'(cfg_done), 32'd1);
      auto_start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
